fetch: RTL and testbench
========================

Name: fetch

Overview:
Instruction fetch unit for the cpu. It sits in front of decode as the producer of the 16-bit instruction word that decode consumes. It keeps the program counter, issues reads to a synchronous-read instruction memory, and buffers returned words in a small prefetch FIFO. Control logic pops one word per ack, redirects the PC on jumps and branches, and can halt prefetching.

Parameters:
ADDR_WIDTH, 13, word address width of instruction memory; the PC wraps modulo 2^ADDR_WIDTH.
BUF_DEPTH, 2, prefetch FIFO depth; must be a power of 2 and at least 2.
RESET_VECTOR, 0, PC value after reset.

Ports:
clk  in  1  sole clock, rising edge.
rst_async  in  1  reset; asynchronous, active-high.
mem_addr  out  ADDR_WIDTH  instruction memory read address (combinational = pc).
mem_rd  out  1  read strobe; data returns on mem_rdata exactly one cycle later.
mem_rdata  in  16  read data, valid the cycle after mem_rd was sampled high.
inst  out  16  head-of-FIFO instruction word, fed to decode's instruction input.
inst_pc  out  ADDR_WIDTH  address of inst.
inst_valid  out  1  FIFO non-empty.
inst_ack  in  1  consumer pops head; ignored when inst_valid=0.
pc_load  in  1  redirect request.
pc_new  in  ADDR_WIDTH  redirect target.
halt  in  1  suppress new memory reads.

Behaviour:
- Reset (async): pc=RESET_VECTOR, FIFO empty, inflight=0. inst_valid=0, inst=0, inst_pc=0; mem_rd is 0 while rst_async is high.
- State held: pc, inflight flag (one read outstanding), FIFO of {word, addr} with count 0..BUF_DEPTH.
- Issue rule (combinational): mem_rd = !rst_async & !halt & !pc_load & ((count+inflight < BUF_DEPTH) | (inst_ack & inst_valid)).
- At any edge with mem_rd=1: pc <= pc+1 (wraps), inflight <= 1, and the read address is recorded as inflight_addr.
- At an edge with mem_rd=0: inflight <= 0.
- At an edge with inflight=1: {mem_rdata, inflight_addr} is pushed. The issue rule guarantees room.
- Push and pop on the same edge: count is unchanged and order is preserved.
- Throughput: 1 instruction per cycle when acked every cycle.
- Startup latency: the first edge after reset release issues the read at RESET_VECTOR. inst_valid goes high after the second edge.
- pc_load (priority over everything):
  - At the edge: pc <= pc_new, FIFO flushed, inflight <= 0.
  - The returning mem_rdata next cycle is discarded.
  - inst_ack in the same cycle has no further effect.
  - The first read at pc_new issues on the following edge; inst_valid returns 2 edges after the load edge.
- halt: no new reads. An in-flight read still lands, the FIFO can still be drained, and pc_load is still honoured. Deasserting halt resumes issuing the same cycle.
- FIFO full with no ack: mem_rd=0, contents and pc stable.
- Reset mid-operation: all state is cleared immediately, and any in-flight data is discarded.
- FIFO storage for words and addresses needs no reset.

Decomposition:
- cpu_common gains FETCH_ADDR_WIDTH and FETCH_RESET_VECTOR constants, used as the defaults, plus an inst_word_t (16-bit) typedef shared with decode.
- One sub-module, fetch_fifo: synchronous FIFO with flush, push/pop, count, and a data width parameter.
- fetch contains the PC, the inflight logic and the issue rule.

Test Plan:
1. Reset release with mem[i]=16'hA000+i -> after 2 edges inst_valid=1, inst=16'hA000, inst_pc=0; no X on outputs during reset.
2. inst_ack held high from the first inst_valid -> inst_pc sequence 0,1,2,3… one per cycle, inst=16'hA000+inst_pc, no gaps.
3. No ack for 10 cycles -> exactly 2 reads issued (mem_rd low afterwards), count=2, pc=2. Then ack once -> inst_pc 0→1 and one new read at addr 2.
4. pc_load=1, pc_new=16'h0100 while a read of addr 5 is in flight -> stale word never appears; next valid inst_pc=16'h0100, 2 edges after the load edge.
5. pc_load with pc_new=16'h1FFF (ADDR_WIDTH=13), ack every cycle -> inst_pc 16'h1FFF then 0, 1.
6. halt raised mid-stream -> the in-flight word still arrives and the FIFO drains. Then rst_async pulsed asynchronously between edges -> inst_valid drops immediately, and the restart fetches RESET_VECTOR.

Source files
------------

// File: rtl/cpu_common.sv
// cpu_common: constants and types shared between fetch and decode
package cpu_common;
  localparam int FETCH_ADDR_WIDTH = 13;
  localparam int unsigned FETCH_RESET_VECTOR = 0;
  typedef logic [15:0] inst_word_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush, head data forced to zero when empty
module fetch_fifo #(
  parameter int DW = 16,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DW-1:0]                wdata_i,
  output logic [DW-1:0]                rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic do_pop;
  assign do_pop = pop_i & (cnt_q != '0);
  assign count_o = cnt_q;
  assign rdata_o = (cnt_q != '0) ? mem_q[rp_q] : '0;
  // pointers and occupancy; flush empties the FIFO in one edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + PW'(1);
      if (do_pop) rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  // storage is only meaningful below cnt_q, so it carries no reset
  always_ff @(posedge clk)
    if (push_i & !flush_i) mem_q[wp_q] <= wdata_i;
endmodule

// File: rtl/fetch.sv
// fetch: program counter, single-outstanding read issue and prefetch buffering
module fetch
  import cpu_common::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int BUF_DEPTH = 2,
  parameter int unsigned RESET_VECTOR = FETCH_RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  rst_async,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  inst_word_t            mem_rdata,
  output inst_word_t            inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ack,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_new,
  input  logic                  halt
);
  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam int DW = $bits(inst_word_t) + ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, ifa_q, ifa_d;
  logic inflight_q, inflight_d;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic [DW-1:0] head;
  logic pop, push;
  // occupancy counts the outstanding read so a returning word always has a slot
  assign occ = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign mem_rd = !rst_async & !halt & !pc_load & ((occ < (CW+1)'(BUF_DEPTH)) | (inst_ack & inst_valid));
  assign mem_addr = pc_q;
  assign inst_valid = count != '0;
  assign {inst, inst_pc} = head;
  assign pop = inst_ack & inst_valid & !pc_load;
  assign push = inflight_q & !pc_load;
  // redirect wins; otherwise advance on issue, and the outstanding flag follows mem_rd
  always_comb begin
    pc_d = pc_load ? pc_new : mem_rd ? pc_q + ADDR_WIDTH'(1) : pc_q;
    inflight_d = mem_rd;
    ifa_d = mem_rd ? pc_q : ifa_q;
  end
  // architectural state
  always_ff @(posedge clk or posedge rst_async)
    if (rst_async) begin
      pc_q <= ADDR_WIDTH'(RESET_VECTOR);
      inflight_q <= 1'b0;
      ifa_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      ifa_q <= ifa_d;
    end
  fetch_fifo #(.DW(DW), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst_async),
    .flush_i(pc_load),
    .push_i(push),
    .pop_i(pop),
    .wdata_i({mem_rdata, ifa_q}),
    .rdata_o(head),
    .count_o(count)
  );
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed self-checking bench for the fetch unit
module tb_fetch;
  logic clk = 1'b0;
  logic rst_async = 1'b0;
  logic [12:0] mem_addr;
  logic mem_rd;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] inst;
  logic [12:0] inst_pc;
  logic inst_valid;
  logic inst_ack = 1'b0;
  logic pc_load = 1'b0;
  logic [12:0] pc_new = 13'h0;
  logic halt = 1'b0;
  int tests = 0;
  int fails = 0;
  int nreads = 0;
  int r0;

  fetch dut (
    .clk(clk), .rst_async(rst_async), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ack(inst_ack), .pc_load(pc_load), .pc_new(pc_new), .halt(halt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd) begin
      mem_rdata <= 16'hA000 + 16'(mem_addr);
      nreads = nreads + 1;
    end

  task automatic do_reset();
    @(negedge clk);
    rst_async = 1'b1;
    inst_ack = 1'b0; pc_load = 1'b0; halt = 1'b0; pc_new = '0;
    @(negedge clk);
    rst_async = 1'b0;
    nreads = 0;
  endtask

  task automatic test_reset();
    #1 rst_async = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if ($isunknown({inst, inst_pc, inst_valid, mem_rd, mem_addr})) begin fails++; $display("FAIL reset_x: outputs %h %h %b %b %h contain X", inst, inst_pc, inst_valid, mem_rd, mem_addr); end
    tests++; if (inst_valid !== 1'b0 || inst !== 16'h0 || inst_pc !== 13'h0) begin fails++; $display("FAIL reset_outs: valid=%b inst=%h pc=%h want 0/0/0", inst_valid, inst, inst_pc); end
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL reset_rd: mem_rd=%b want 0", mem_rd); end
    rst_async = 1'b0;
    nreads = 0;
    #1;
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 13'h0) begin fails++; $display("FAIL first_issue: rd=%b addr=%h want 1/0", mem_rd, mem_addr); end
    @(negedge clk);
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL latency_1: valid=%b want 0", inst_valid); end
    @(negedge clk);
    tests++; if (inst_valid !== 1'b1 || inst !== 16'hA000 || inst_pc !== 13'h0) begin fails++; $display("FAIL latency_2: valid=%b inst=%h pc=%h want 1/A000/0", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    repeat (2) @(negedge clk);
    inst_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++; if (inst_valid !== 1'b1 || inst_pc !== 13'(i) || inst !== 16'hA000 + 16'(i)) begin fails++; $display("FAIL stream_%0d: valid=%b pc=%h inst=%h want 1/%h/%h", i, inst_valid, inst_pc, inst, 13'(i), 16'hA000 + 16'(i)); end
      @(negedge clk);
    end
    inst_ack = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    repeat (10) @(negedge clk);
    tests++; if (nreads !== 2 || mem_rd !== 1'b0) begin fails++; $display("FAIL full_reads: reads=%0d rd=%b want 2/0", nreads, mem_rd); end
    tests++; if (dut.count !== 2'd2 || mem_addr !== 13'h2 || inst_pc !== 13'h0) begin fails++; $display("FAIL full_state: count=%0d pc=%h head=%h want 2/2/0", dut.count, mem_addr, inst_pc); end
    inst_ack = 1'b1;
    #1;
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 13'h2) begin fails++; $display("FAIL full_ack_issue: rd=%b addr=%h want 1/2", mem_rd, mem_addr); end
    @(negedge clk);
    inst_ack = 1'b0;
    tests++; if (inst_pc !== 13'h1 || inst !== 16'hA001 || nreads !== 3) begin fails++; $display("FAIL full_pop: pc=%h inst=%h reads=%0d want 1/A001/3", inst_pc, inst, nreads); end
    @(negedge clk);
    tests++; if (dut.count !== 2'd2 || nreads !== 3 || mem_rd !== 1'b0) begin fails++; $display("FAIL full_refill: count=%0d reads=%0d rd=%b want 2/3/0", dut.count, nreads, mem_rd); end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (2) @(negedge clk);
    inst_ack = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (inst_pc !== 13'h4 || dut.inflight_q !== 1'b1 || dut.ifa_q !== 13'h5) begin fails++; $display("FAIL redir_setup: head=%h inflight=%b ifa=%h want 4/1/5", inst_pc, dut.inflight_q, dut.ifa_q); end
    pc_load = 1'b1; pc_new = 13'h0100;
    #1;
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL redir_rd: rd=%b want 0", mem_rd); end
    @(negedge clk);
    pc_load = 1'b0;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL redir_flush: valid=%b pc=%h want 0", inst_valid, inst_pc); end
    #1;
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 13'h0100) begin fails++; $display("FAIL redir_issue: rd=%b addr=%h want 1/0100", mem_rd, mem_addr); end
    @(negedge clk);
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL redir_stale: valid=%b pc=%h want 0", inst_valid, inst_pc); end
    @(negedge clk);
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 13'h0100 || inst !== 16'hA100) begin fails++; $display("FAIL redir_target: valid=%b pc=%h inst=%h want 1/0100/A100", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_wrap();
    inst_ack = 1'b1; pc_load = 1'b1; pc_new = 13'h1FFF;
    @(negedge clk);
    pc_load = 1'b0;
    @(negedge clk);
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL wrap_gap: valid=%b want 0", inst_valid); end
    @(negedge clk);
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 13'h1FFF || inst !== 16'hBFFF) begin fails++; $display("FAIL wrap_top: valid=%b pc=%h inst=%h want 1/1FFF/BFFF", inst_valid, inst_pc, inst); end
    @(negedge clk);
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 13'h0 || inst !== 16'hA000) begin fails++; $display("FAIL wrap_zero: valid=%b pc=%h inst=%h want 1/0000/A000", inst_valid, inst_pc, inst); end
    @(negedge clk);
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 13'h1 || inst !== 16'hA001) begin fails++; $display("FAIL wrap_one: valid=%b pc=%h inst=%h want 1/0001/A001", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_halt_reset();
    halt = 1'b1; inst_ack = 1'b0;
    r0 = nreads;
    #1;
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL halt_rd: rd=%b want 0", mem_rd); end
    @(negedge clk);
    tests++; if (dut.count !== 2'd2 || inst_pc !== 13'h1) begin fails++; $display("FAIL halt_land: count=%0d head=%h want 2/0001", dut.count, inst_pc); end
    inst_ack = 1'b1;
    @(negedge clk);
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 13'h2 || inst !== 16'hA002) begin fails++; $display("FAIL halt_drain: valid=%b pc=%h inst=%h want 1/0002/A002", inst_valid, inst_pc, inst); end
    @(negedge clk);
    inst_ack = 1'b0;
    tests++; if (inst_valid !== 1'b0 || nreads !== r0 || mem_addr !== 13'h3) begin fails++; $display("FAIL halt_empty: valid=%b reads=%0d pc=%h want 0/%0d/0003", inst_valid, nreads, mem_addr, r0); end
    halt = 1'b0;
    #1;
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 13'h3) begin fails++; $display("FAIL halt_resume: rd=%b addr=%h want 1/0003", mem_rd, mem_addr); end
    repeat (2) @(negedge clk);
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 13'h3 || inst !== 16'hA003) begin fails++; $display("FAIL halt_after: valid=%b pc=%h inst=%h want 1/0003/A003", inst_valid, inst_pc, inst); end
    #2 rst_async = 1'b1;
    #1;
    tests++; if (inst_valid !== 1'b0 || inst !== 16'h0 || mem_rd !== 1'b0 || mem_addr !== 13'h0) begin fails++; $display("FAIL async_rst: valid=%b inst=%h rd=%b pc=%h want 0/0/0/0", inst_valid, inst, mem_rd, mem_addr); end
    #1 rst_async = 1'b0;
    @(negedge clk);
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL restart_1: valid=%b want 0", inst_valid); end
    @(negedge clk);
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 13'h0 || inst !== 16'hA000) begin fails++; $display("FAIL restart_2: valid=%b pc=%h inst=%h want 1/0000/A000", inst_valid, inst_pc, inst); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_wrap();
    test_halt_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
